stream_rr_arbiter: RTL and testbench
====================================

# stream_rr_arbiter

Round-robin arbiter that shares one registered valid/ready pipeline stage between NUM_REQ upstream streams. It sits in front of a downstream consumer and merges several producers onto one channel. It tags each output beat with its source index and sustains one beat per cycle with one cycle of latency.

## Interface
- DATAWIDTH, 8, payload width per beat
- NUM_REQ, 4, number of requesters (2..16)
- IDXW, $clog2(NUM_REQ), width of source index (derived, not overridden)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  NUM_REQ  per-requester valid
- in_data  in  NUM_REQ*DATAWIDTH  flattened payloads; requester i at [i*DATAWIDTH +: DATAWIDTH]
- in_last  in  NUM_REQ  per-requester end-of-packet flag
- in_ready  out  NUM_REQ  per-requester ready; one-hot or zero
- out_valid  out  1  registered output valid
- out_data  out  DATAWIDTH  registered payload
- out_src  out  IDXW  index of requester that produced out_data
- out_last  out  1  registered copy of the granted in_last
- out_ready  in  1  downstream ready

## Operation
- The stage is free when `~out_valid | out_ready`. A stalled full stage therefore still accepts a new beat when out_ready is high.
- When the stage is free and any in_valid is set, the arbiter grants the first set bit found searching from index ptr upward, wrapping modulo NUM_REQ.
- in_ready[g] is asserted for the granted index g only. All other in_ready bits are 0.
  - in_ready is combinational from in_valid, ptr, lock state and out_ready.
  - When the stage is not free, all in_ready bits are 0.
- On acceptance (in_valid[g] & in_ready[g]), at the next edge:
  - out_data <= in_data[g]
  - out_src <= g
  - out_last <= in_last[g]
  - out_valid <= 1
- When the stage is free and no requester is valid: out_valid <= 0. out_data, out_src and out_last hold their values.
- Pointer update: ptr <= (g+1) mod NUM_REQ on each acceptance, except as modified under Configuration.
- A requester deasserting in_valid while not granted is legal. Arbitration never drops or duplicates a beat.
- Fairness: with all requesters continuously valid and out_ready=1, grants cycle 0,1,…,NUM_REQ-1,0,…

## Timing
- Latency: one cycle from acceptance to out_valid.
- Throughput: one beat per cycle, with no bubble under continuous traffic.
- Backpressure: while out_valid=1 and out_ready=0, out_* are held stable and in_ready=0.
- Simultaneous events: when out_ready=1 and a new acceptance occur in the same cycle, the output is replaced with no gap.
- Reset values:
  - out_valid=0, out_data=0, out_src=0, out_last=0
  - ptr=0, lock cleared
  - in_ready=0 during rst
- Reset asserted mid-stream discards the held beat and any packet lock. The first post-reset grant searches from index 0.

## Configuration
- Macro: STREAM_RR_ARBITER_PKT_LOCK_EN.
- Defined: packet-lock mode.
  - An accepted beat with in_last=0 locks the grant to that requester.
  - Only that requester may be granted until its beat with in_last=1 is accepted.
  - ptr advances only on that last beat, to (g+1) mod NUM_REQ.
  - While locked, a stall of the locked requester (in_valid low) does not release the lock.
- Undefined: every beat arbitrates independently. in_last is only passed through to out_last and has no effect on grants.

## Structure
- Package stream_arb_pkg:
  - default DATAWIDTH and NUM_REQ constants
  - an index-width helper function
  - the lock-state encoding: UNLOCKED / LOCKED
- One sub-module, rr_priority_pick, is natural:
  - combinational rotate-and-find-first
  - inputs: request vector and ptr
  - outputs: one-hot grant, binary index, any flag

## Test plan
- Reset: hold rst=1 for 2 cycles with all in_valid=1. Required: in_ready=0, out_valid=0, out_data=0, out_src=0 after reset.
- Fair rotation: NUM_REQ=4, all valid, out_ready=1, in_data[i]=8'hA0+i. Required: out_data sequence A0,A1,A2,A3,A0 with out_src 0,1,2,3,0, one beat per cycle.
- Sparse wrap: only requesters 3 and 1 valid, ptr=0. Required: grant order 1,3,1,3.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1. Required: out_data and out_src stable, in_ready=0; when out_ready returns to 1, the next beat is accepted that same cycle.
- Packet lock (macro defined): requester 0 sends beats with in_last 0,0,1 while requester 1 is continuously valid. Required: out_src 0,0,0,1. Without the macro: out_src 0,1,0,1,…
- Mid-operation reset: assert rst for 1 cycle while locked with out_valid=1. Required: out_valid=0 next cycle, and the next grant goes to the lowest valid index.

Source files
------------

// File: rtl/stream_arb_pkg.sv
// Shared constants, index-width helper and lock-state encoding for stream_rr_arbiter.
package stream_arb_pkg;

    localparam int DEFAULT_DATAWIDTH = 8;
    localparam int DEFAULT_NUM_REQ   = 4;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotate-and-find-first: picks the first set request at or after ptr, wrapping.
module rr_priority_pick
    import stream_arb_pkg::*;
#(
    parameter int N  = DEFAULT_NUM_REQ,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Walk offsets from farthest to nearest so the closest hit to ptr wins.
    always_comb begin
        int c;
        c     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            c = (int'(ptr) + k) % N;
            if (req[IW'(c)]) begin
                grant            = '0;
                grant[IW'(c)]    = 1'b1;
                idx              = IW'(c);
                any              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin merge of NUM_REQ streams into one registered valid/ready stage tagged with source index.
// Define STREAM_RR_ARBITER_PKT_LOCK_EN to hold the grant on one requester until its in_last beat.
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int  DATAWIDTH = DEFAULT_DATAWIDTH,
    parameter int  NUM_REQ   = DEFAULT_NUM_REQ,
    localparam int IDXW      = idx_width(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           in_valid,
    input  logic [NUM_REQ*DATAWIDTH-1:0] in_data,
    input  logic [NUM_REQ-1:0]           in_last,
    output logic [NUM_REQ-1:0]           in_ready,
    output logic                         out_valid,
    output logic [DATAWIDTH-1:0]         out_data,
    output logic [IDXW-1:0]              out_src,
    output logic                         out_last,
    input  logic                         out_ready
);

    logic [IDXW-1:0]      ptr;
    logic [NUM_REQ-1:0]   req_eff;
    logic [NUM_REQ-1:0]   grant;
    logic [IDXW-1:0]      grant_idx;
    logic [IDXW-1:0]      ptr_after_grant;
    logic                 grant_any;
    logic                 stage_free;
    logic                 accept;
    logic                 ptr_advance;
    logic [DATAWIDTH-1:0] sel_data;
    logic                 sel_last;

    rr_priority_pick #(
        .N  (NUM_REQ),
        .IW (IDXW)
    ) u_pick (
        .req   (req_eff),
        .ptr   (ptr),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    assign stage_free      = ~out_valid | out_ready;
    assign accept          = grant_any & stage_free & ~rst;
    assign in_ready        = accept ? grant : '0;
    assign ptr_after_grant = IDXW'((int'(grant_idx) + 1) % NUM_REQ);

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_data = in_data[i*DATAWIDTH +: DATAWIDTH];
            end
        end
        sel_last = |(in_last & grant);
    end

`ifdef STREAM_RR_ARBITER_PKT_LOCK_EN
    lock_state_t     lock_state, lock_state_next;
    logic [IDXW-1:0] lock_idx, lock_idx_next;

    // While locked, only the owning requester is visible to the picker, even if it stalls.
    always_comb begin
        req_eff = in_valid;
        if (lock_state == LOCKED) begin
            req_eff = in_valid & (NUM_REQ'(1) << lock_idx);
        end
    end

    always_comb begin
        lock_state_next = lock_state;
        lock_idx_next   = lock_idx;
        ptr_advance     = 1'b0;
        if (accept) begin
            if (sel_last) begin
                lock_state_next = UNLOCKED;
                ptr_advance     = 1'b1;
            end else begin
                lock_state_next = LOCKED;
                lock_idx_next   = grant_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_state <= UNLOCKED;
            lock_idx   <= '0;
        end else begin
            lock_state <= lock_state_next;
            lock_idx   <= lock_idx_next;
        end
    end
`else
    assign req_eff     = in_valid;
    assign ptr_advance = accept;
`endif

    // Payload fields only change on acceptance; an idle free stage just drops valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            out_last  <= 1'b0;
            ptr       <= '0;
        end else begin
            if (stage_free) begin
                if (accept) begin
                    out_valid <= 1'b1;
                    out_data  <= sel_data;
                    out_src   <= grant_idx;
                    out_last  <= sel_last;
                end else begin
                    out_valid <= 1'b0;
                end
            end
            if (ptr_advance) begin
                ptr <= ptr_after_grant;
            end
        end
    end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Self-checking bench for stream_rr_arbiter: directed steps then random traffic against a reference model.
module tb_stream_rr_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;

    logic            clk;
    logic            rst;
    logic [NR-1:0]   in_valid;
    logic [NR*DW-1:0] in_data;
    logic [NR-1:0]   in_last;
    logic [NR-1:0]   in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_src;
    logic            out_last;
    logic            out_ready;

    int checks = 0;
    int fails  = 0;

    // Reference model state: the stage contents, the rotation pointer and the locked owner (-1 = none).
    logic            m_valid = 1'b0;
    logic [DW-1:0]   m_data  = '0;
    int              m_src   = 0;
    logic            m_last  = 1'b0;
    int              m_ptr   = 0;
    int              m_lock  = -1;
    logic [NR-1:0]   last_ready;

    stream_rr_arbiter #(
        .DATAWIDTH (DW),
        .NUM_REQ   (NR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [NR-1:0] v, input logic [DW-1:0] d0,
                                 input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                                 input logic [DW-1:0] d3, input logic [NR-1:0] l, input logic ordy);
        rst       = r;
        in_valid  = v;
        in_data   = {d3, d2, d1, d0};
        in_last   = l;
        out_ready = ordy;
    endtask

    // One clock: check in_ready mid-cycle, advance the model, check the registered outputs after the edge.
    task automatic stepCycle();
        int            g;
        int            idx;
        logic          free;
        logic [NR-1:0] exp_rdy;
        logic [DW-1:0] beat;
        @(negedge clk);
        g       = -1;
        exp_rdy = '0;
        free    = !m_valid || out_ready;
        if (!rst && free) begin
            for (int k = 0; k < NR; k++) begin
                idx = (m_ptr + k) % NR;
                if (g < 0 && in_valid[idx] && (m_lock < 0 || m_lock == idx)) g = idx;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        last_ready = in_ready;
        checkOutput("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (rst) begin
            m_valid = 1'b0; m_data = '0; m_src = 0; m_last = 1'b0; m_ptr = 0; m_lock = -1;
        end else if (free) begin
            if (g >= 0) begin
                beat    = in_data[g*DW +: DW];
                m_valid = 1'b1;
                m_data  = beat;
                m_src   = g;
                m_last  = in_last[g];
`ifdef STREAM_RR_ARBITER_PKT_LOCK_EN
                if (in_last[g]) begin
                    m_lock = -1;
                    m_ptr  = (g + 1) % NR;
                end else begin
                    m_lock = g;
                end
`else
                m_ptr = (g + 1) % NR;
`endif
            end else begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
        checkOutput("out_data",  32'(out_data),  32'(m_data));
        checkOutput("out_src",   32'(out_src),   32'(m_src));
        checkOutput("out_last",  32'(out_last),  32'(m_last));
    endtask

    initial begin
        int sent;
        logic [DW-1:0] rd [NR];
        applyStimulus(1'b1, 4'b1111, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b1);

        // Reset held with every requester valid.
        $display("[TB] reset");
        stepCycle();
        checkOutput("rst_in_ready", 32'(last_ready), 32'h0);
        stepCycle();
        checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_out_data",  32'(out_data),  32'h0);
        checkOutput("rst_out_src",   32'(out_src),   32'h0);

        // Fair rotation with everyone valid.
        $display("[TB] fair rotation");
        applyStimulus(1'b0, 4'b1111, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 4'b1111, 1'b1);
        for (int i = 0; i < 5; i++) begin
            stepCycle();
            checkOutput("rot_valid", 32'(out_valid), 32'h1);
            checkOutput("rot_src",   32'(out_src),   32'(i % NR));
            checkOutput("rot_data",  32'(out_data),  32'(8'hA0 + (i % NR)));
        end

        // Sparse wrap: only 1 and 3 valid, from a fresh pointer.
        $display("[TB] sparse wrap");
        applyStimulus(1'b1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 4'b1010, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 4'b1111, 1'b1);
        for (int i = 0; i < 4; i++) begin
            stepCycle();
            checkOutput("sparse_src", 32'(out_src), (i % 2 == 0) ? 32'd1 : 32'd3);
        end

        // Backpressure: stall three cycles, then release.
        $display("[TB] backpressure");
        applyStimulus(1'b0, 4'b1111, 8'hC0, 8'hC1, 8'hC2, 8'hC3, 4'b0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkOutput("bp_in_ready", 32'(last_ready), 32'h0);
            checkOutput("bp_hold_src", 32'(out_src), 32'd3);
        end
        out_ready = 1'b1;
        stepCycle();
        checkOutput("bp_resume", 32'(|last_ready), 32'h1);

        // Packet from requester 0 (last on its third beat) against a continuously valid requester 1.
        $display("[TB] packet lock");
        applyStimulus(1'b1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b1);
        stepCycle();
        sent = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, {2'b00, 1'b1, (sent < 3)}, 8'(8'h10 + sent), 8'h21, 8'h00, 8'h00,
                          {3'b001, (sent == 2)}, 1'b1);
            stepCycle();
            if (last_ready[0]) sent++;
`ifdef STREAM_RR_ARBITER_PKT_LOCK_EN
            checkOutput("lock_src", 32'(out_src), (i < 3) ? 32'd0 : 32'd1);
`else
            checkOutput("lock_src", 32'(out_src), (i % 2 == 0) ? 32'd0 : 32'd1);
`endif
        end

        // Reset in the middle of a packet with a beat held in the stage.
        $display("[TB] mid-stream reset");
        applyStimulus(1'b1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 4'b0100, 8'h00, 8'h00, 8'h52, 8'h00, 4'b0000, 1'b0);
        stepCycle();
        checkOutput("mid_pre_valid", 32'(out_valid), 32'h1);
        applyStimulus(1'b1, 4'b0110, 8'h00, 8'h61, 8'h62, 8'h00, 4'b0000, 1'b0);
        stepCycle();
        checkOutput("mid_rst_valid", 32'(out_valid), 32'h0);
        rst = 1'b0;
        stepCycle();
        checkOutput("mid_post_src",  32'(out_src),   32'd1);
        checkOutput("mid_post_data", 32'(out_data),  32'h61);

        // Random traffic against the model.
        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            for (int r = 0; r < NR; r++) rd[r] = 8'($urandom);
            applyStimulus(($urandom_range(0, 39) == 0), 4'($urandom), rd[0], rd[1], rd[2], rd[3],
                          4'($urandom), ($urandom_range(0, 3) != 0));
            stepCycle();
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
